// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder with carry-in that time-shares one
// half_adder. Each bit is processed LSB first in two phases: PH_A half-adds the
// operand bits, PH_B half-adds that partial sum with the running carry.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   WIDTH-bit operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   busy   high while in PH_A/PH_B
//   done   one-cycle pulse when sum/cout are valid
//   sum    result register, held until the next accepted start
//   cout   carry-out register, held until the next accepted start

// Shared combinational half adder leaf cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Operands shift right once per bit so the current bit is always at [0].
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             s1;
    logic             c1;

    logic             ha_a;
    logic             ha_b;
    logic             ha_sum;
    logic             ha_cout;

    half_adder u_ha (
        .a    (ha_a),
        .b    (ha_b),
        .sum  (ha_sum),
        .cout (ha_cout)
    );

    // Next-state and half-adder input steering.
    always_comb begin
        state_nxt = state;
        ha_a      = 1'b0;
        ha_b      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PH_A;
                end
            end
            PH_A: begin
                ha_a      = opa[0];
                ha_b      = opb[0];
                state_nxt = PH_B;
            end
            PH_B: begin
                ha_a      = s1;
                ha_b      = carry;
                state_nxt = (idx == LAST_IDX) ? DONE : PH_A;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == PH_A) || (state_nxt == PH_B);
            done  <= (state_nxt == DONE);
        end
    end

    // Datapath: operand capture, per-phase partial results, in-place sum update.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            s1    <= 1'b0;
            c1    <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                PH_A: begin
                    s1  <= ha_sum;
                    c1  <= ha_cout;
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                end
                PH_B: begin
                    for (int unsigned k = 0; k < WIDTH; k++) begin
                        if (idx == IDX_W'(k)) begin
                            sum[k] <= ha_sum;
                        end
                    end
                    carry <= c1 | ha_cout;
                    if (idx == LAST_IDX) begin
                        cout <= c1 | ha_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int vectors;
    int miscompares;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, result bit 8 is the carry-out.
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // Drive one request and wait (bounded) for done; optionally scramble inputs
    // (including start) while the add is in flight.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           input bit scramble,
                           output logic [7:0] rs, output logic rc, output int lat,
                           output int nbusy, output logic done_after);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                start = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        rs = sum;
        rc = cout;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        logic [7:0] rs; logic rc; int lat; int nb; logic da;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL reset_sum: got %h want 00", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", cout); end
        rst = 1'b0;
        run_add(8'h00, 8'h00, 1'b0, 1'b0, rs, rc, lat, nb, da);
        vectors++; if (lat != 16) begin miscompares++; $display("FAIL zero_latency: got %0d want 16", lat); end
        vectors++; if ({rc, rs} !== 9'h000) begin miscompares++; $display("FAIL zero_result: got %b_%h want 0_00", rc, rs); end
    endtask

    task automatic test_directed();
        logic [7:0] va [4] = '{8'h3C, 8'hFF, 8'hA5, 8'h80};
        logic [7:0] vb [4] = '{8'h0F, 8'h01, 8'h5A, 8'h80};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [8:0] exp_v;
        logic [7:0] rs; logic rc; int lat; int nb; logic da;
        for (int i = 0; i < 4; i++) begin
            exp_v = ref_add(va[i], vb[i], vc[i]);
            run_add(va[i], vb[i], vc[i], 1'b0, rs, rc, lat, nb, da);
            vectors++; if ({rc, rs} !== exp_v) begin miscompares++; $display("FAIL directed_result[%0d]: got %b_%h want %b_%h", i, rc, rs, exp_v[8], exp_v[7:0]); end
            vectors++; if (lat != 16) begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d want 16", i, lat); end
            vectors++; if (nb != 16) begin miscompares++; $display("FAIL directed_busy_cycles[%0d]: got %0d want 16", i, nb); end
            vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL directed_done_width[%0d]: got %b want 0", i, da); end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra; logic [7:0] rb; logic rcn;
        logic [8:0] exp_v;
        logic [7:0] rs; logic rc; int lat; int nb; logic da;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcn = 1'($urandom);
            exp_v = ref_add(ra, rb, rcn);
            run_add(ra, rb, rcn, 1'b1, rs, rc, lat, nb, da);
            vectors++; if ({rc, rs} !== exp_v || lat != 16) begin miscompares++; $display("FAIL random[%0d] %h+%h+%b: got %b_%h lat %0d want %b_%h lat 16", i, ra, rb, rcn, rc, rs, lat, exp_v[8], exp_v[7:0]); end
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (k == 6) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                vectors++; if ({cout, sum} !== 9'h033) begin miscompares++; $display("FAIL busy_start_result: got %b_%h want 0_33", cout, sum); end
            end
            @(negedge clk);
        end
        vectors++; if (ndone != 1) begin miscompares++; $display("FAIL busy_start_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_midflight();
        int ndone;
        logic [7:0] rs; logic rc; int lat; int nb; logic da;
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL midreset_ctrl: got busy %b done %b want 0 0", busy, done); end
        vectors++; if ({cout, sum} !== 9'h000) begin miscompares++; $display("FAIL midreset_result: got %b_%h want 0_00", cout, sum); end
        ndone = 0;
        for (int k = 0; k < 24; k++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            @(negedge clk);
        end
        vectors++; if (ndone != 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles want 0", ndone); end
        run_add(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, lat, nb, da);
        vectors++; if ({rc, rs} !== 9'h002) begin miscompares++; $display("FAIL midreset_next: got %b_%h want 0_02", rc, rs); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h81; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        vectors++; if ({cout, sum} !== ref_add(8'h7F, 8'h81, 1'b1) || lat != 16) begin miscompares++; $display("FAIL b2b_first: got %b_%h lat %0d want 1_01 lat 16", cout, sum, lat); end
        // Start held from the DONE cycle: ignored in DONE, accepted one edge later.
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_ignore: got busy %b want 0", busy); end
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        start = 1'b0; a = 8'hAA; b = 8'hAA;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        vectors++; if ({cout, sum} !== 9'h010 || lat != 16) begin miscompares++; $display("FAIL b2b_second: got %b_%h lat %0d want 0_10 lat 16", cout, sum, lat); end
    endtask

    task automatic test_width1();
        int lat;
        int total;
        for (int v = 7; v >= 0; v--) begin
            @(negedge clk);
            start1 = 1'b1; a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (done1 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            total = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            vectors++; if ({cout1, sum1} !== 2'(total) || lat != 2) begin miscompares++; $display("FAIL width1[%0d]: got %b%b lat %0d want %b lat 2", v, cout1, sum1, lat, 2'(total)); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_midflight();
        test_back_to_back();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
